// File: rtl/seq_pkg.sv
// Shared constants for the serial sequence detector slice.
// Status codes driven on y and the y bus width.
package seq_pkg;

  localparam int Y_W = 2;

  localparam logic [Y_W-1:0] ST_FILL  = 2'b00;
  localparam logic [Y_W-1:0] ST_ARMED = 2'b01;
  localparam logic [Y_W-1:0] ST_HIT   = 2'b10;
  localparam logic [Y_W-1:0] ST_SAT   = 2'b11;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter, reused by the event counters.
// Ports: clk, rst (sync, active-low), inc, q (count), full (q all-ones).
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] q,
  output logic         full
);

  assign full = &q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      q <= '0;
    end else if (inc && !full) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/seq_detect_param.sv
// Parametrised serial pattern detector with saturating match count.
// Ports: clk, rst (sync, active-low), en, x in; match, count, y out.
module seq_detect_param
  import seq_pkg::*;
#(
  parameter int LEN     = 4,
  parameter     PATTERN = 4'b1011,
  parameter bit OVERLAP = 1'b1,
  parameter int COUNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               x,
  output logic               match,
  output logic [COUNT_W-1:0] count,
  output logic [Y_W-1:0]     y
);

  if ($bits(PATTERN) != LEN || LEN < 2) begin : g_bad_cfg
    $error("seq_detect_param: PATTERN width must equal LEN >= 2");
  end

  localparam int             FW    = $clog2(LEN + 1);
  localparam logic [FW-1:0]  LEN_F = FW'(LEN);
  localparam logic [LEN-1:0] PAT   = PATTERN[LEN-1:0];

  logic [LEN-1:0]     hist;
  logic [LEN-1:0]     hist_n;
  logic [LEN-1:0]     hist_d;
  logic [FW-1:0]      fill;
  logic [FW-1:0]      fill_n;
  logic [FW-1:0]      fill_d;
  logic               hit;
  logic               full;
  logic               sat_d;
  logic [COUNT_W-1:0] cnt_inc;
  logic [Y_W-1:0]     y_d;

  sat_counter #(
    .W (COUNT_W)
  ) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (hit),
    .q    (count),
    .full (full)
  );

  always_comb begin
    hist_n = {hist[LEN-2:0], x};
    fill_n = (fill == LEN_F) ? LEN_F : fill + 1'b1;
    // fill gate keeps the reset-zero history from
    // matching patterns with leading zeros
    hit    = en && (hist_n == PAT) && (fill_n == LEN_F);
    hist_d = en ? hist_n : hist;
    fill_d = fill;
    if (en) begin
      fill_d = (hit && !OVERLAP) ? '0 : fill_n;
    end
  end

  // y reflects post-edge count/match/fill, so it
  // looks ahead at the counter's next value
  always_comb begin
    cnt_inc = count + 1'b1;
    sat_d   = full || (hit && (&cnt_inc));
    if (sat_d) begin
      y_d = ST_SAT;
    end else if (hit) begin
      y_d = ST_HIT;
    end else if (fill_d == LEN_F) begin
      y_d = ST_ARMED;
    end else begin
      y_d = ST_FILL;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      hist  <= '0;
      fill  <= '0;
      match <= 1'b0;
      y     <= ST_FILL;
    end else begin
      hist  <= hist_d;
      fill  <= fill_d;
      match <= hit;
      y     <= y_d;
    end
  end

endmodule

// File: tb/tb_seq_detect_param.sv
// Self-checking bench for seq_detect_param: four configurations
// on one stimulus stream, stream-level model plus literal checks.
module tb_seq_detect_param;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en  = 1'b0;
  logic x   = 1'b0;

  always #5 clk = ~clk;

  logic       m0, m1, m2, m3;
  logic [7:0] c0, c1, c3;
  logic [1:0] c2;
  logic [1:0] y0, y1, y2, y3;

  seq_detect_param u0 (
    .clk(clk), .rst(rst), .en(en), .x(x),
    .match(m0), .count(c0), .y(y0)
  );

  seq_detect_param #(.OVERLAP(1'b0)) u1 (
    .clk(clk), .rst(rst), .en(en), .x(x),
    .match(m1), .count(c1), .y(y1)
  );

  seq_detect_param #(.COUNT_W(2)) u2 (
    .clk(clk), .rst(rst), .en(en), .x(x),
    .match(m2), .count(c2), .y(y2)
  );

  seq_detect_param #(.PATTERN(4'b0011)) u3 (
    .clk(clk), .rst(rst), .en(en), .x(x),
    .match(m3), .count(c3), .y(y3)
  );

  int nchk  = 0;
  int nfail = 0;

  task automatic check(string name, int act, int exp);
    nchk++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d @%0t",
               name, act, exp, $time);
    end
  endtask

  // ---- stream-level model ----
  bit sb[2048];
  int n = 0;
  int start[4];
  int ecnt[4];
  bit em[4];
  int ey[4];
  bit started = 1'b0;

  function automatic bit [3:0] pat_of(int i);
    return (i == 3) ? 4'b0011 : 4'b1011;
  endfunction

  function automatic bit ovl_of(int i);
    return i != 1;
  endfunction

  function automatic int max_of(int i);
    return (i == 2) ? 3 : 255;
  endfunction

  // last 4 enabled bits since start[i] (nb newest) == pattern
  function automatic bit win(int i, bit nb);
    bit [3:0] p;
    p = pat_of(i);
    if (n + 1 - start[i] < 4) return 1'b0;
    for (int k = 0; k < 3; k++)
      if (sb[n-3+k] != p[3-k]) return 1'b0;
    return nb == p[0];
  endfunction

  function automatic int ncnt(int i, bit h);
    if (h && ecnt[i] < max_of(i)) return ecnt[i] + 1;
    return ecnt[i];
  endfunction

  function automatic int nst(int i, bit h);
    return (h && !ovl_of(i)) ? n + 1 : start[i];
  endfunction

  function automatic int ystat(int i, int c, bit h, bit armed);
    if (c == max_of(i)) return 3;
    if (h) return 2;
    if (armed) return 1;
    return 0;
  endfunction

  always @(posedge clk) begin
    if (!rst) begin
      started <= 1'b1;
      for (int i = 0; i < 4; i++) begin
        start[i] <= n;
        ecnt[i]  <= 0;
        em[i]    <= 1'b0;
        ey[i]    <= 0;
      end
    end else if (en) begin
      sb[n] <= x;
      n     <= n + 1;
      for (int i = 0; i < 4; i++) begin
        em[i]    <= win(i, x);
        ecnt[i]  <= ncnt(i, win(i, x));
        start[i] <= nst(i, win(i, x));
        ey[i]    <= ystat(i, ncnt(i, win(i, x)), win(i, x),
                          (n + 1 - nst(i, win(i, x))) >= 4);
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        em[i] <= 1'b0;
        ey[i] <= ystat(i, ecnt[i], 1'b0, (n - start[i]) >= 4);
      end
    end
  end

  function automatic int act_m(int i);
    case (i)
      0: return int'(m0);
      1: return int'(m1);
      2: return int'(m2);
      default: return int'(m3);
    endcase
  endfunction

  function automatic int act_c(int i);
    case (i)
      0: return int'(c0);
      1: return int'(c1);
      2: return int'(c2);
      default: return int'(c3);
    endcase
  endfunction

  function automatic int act_y(int i);
    case (i)
      0: return int'(y0);
      1: return int'(y1);
      2: return int'(y2);
      default: return int'(y3);
    endcase
  endfunction

  always @(negedge clk) begin
    if (started) begin
      for (int i = 0; i < 4; i++) begin
        check($sformatf("model_match%0d", i), act_m(i), int'(em[i]));
        check($sformatf("model_count%0d", i), act_c(i), ecnt[i]);
        check($sformatf("model_y%0d", i), act_y(i), ey[i]);
      end
    end
  end

  // ---- directed stimulus ----
  task automatic drive(bit r, bit e, bit b);
    rst = r;
    en  = e;
    x   = b;
    @(posedge clk);
    #2;
  endtask

  task automatic send4(bit [3:0] v);
    for (int k = 3; k >= 0; k--) drive(1'b1, 1'b1, v[k]);
  endtask

  int sat_exp[6] = '{1, 2, 3, 3, 3, 3};

  initial begin
    drive(1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    check("rst_count", c0, 0);
    check("rst_y", y0, 0);
    check("rst_match", m0, 0);

    send4(4'b1011);
    check("first_match", m0, 1);
    check("first_y", y0, 2);
    check("first_count", c0, 1);
    check("novl_first", c1, 1);
    drive(1'b1, 1'b1, 1'b0);
    check("after_match", m0, 0);
    check("after_y", y0, 1);
    drive(1'b1, 1'b1, 1'b1);
    drive(1'b1, 1'b1, 1'b1);
    check("ovl_match2", m0, 1);
    check("ovl_count", c0, 2);
    check("novl_match2", m1, 0);
    check("novl_count", c1, 1);
    check("novl_y", y1, 0);

    drive(1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b1);
    drive(1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b1);
    drive(1'b0, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b1);
    check("midrst_match", m0, 0);
    check("midrst_count", c0, 0);
    check("midrst_y", y0, 0);

    drive(1'b0, 1'b0, 1'b0);
    for (int k = 3; k >= 0; k--) begin
      bit [3:0] v;
      v = 4'b1011;
      drive(1'b1, 1'b1, v[k]);
      if (k == 0) check("gap_match", m0, 1);
      for (int g = 0; g < 3; g++) drive(1'b1, 1'b0, ~v[k]);
      if (k == 2) check("gap_hist", u0.hist, 2);
    end
    check("gap_count", c0, 1);
    check("gap_y", y0, 1);

    drive(1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 6; k++) begin
      send4(4'b1011);
      check($sformatf("sat_count%0d", k), c2, sat_exp[k]);
      check($sformatf("sat_match%0d", k), m2, 1);
      check($sformatf("sat_y%0d", k), y2, (k >= 2) ? 3 : 2);
    end

    drive(1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b1);
    check("lz_m_a", m3, 0);
    drive(1'b1, 1'b1, 1'b1);
    check("lz_m_b", m3, 0);
    check("lz_count0", c3, 0);
    send4(4'b0011);
    check("lz_hit", m3, 1);
    check("lz_count1", c3, 1);

    drive(1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             nchk, nfail);
    $finish;
  end

endmodule

// File: doc/seq_detect_param.md
# seq_detect_param

Parametrised serial pattern detector with a 2-bit status output. It samples one serial bit `x` per enabled clock and pulses `match` when the most recent `LEN` bits equal `PATTERN`. It supports overlapping and non-overlapping detection and keeps a saturating match counter. It sits on a serial input stream in the lab datapath and replaces fixed, hand-coded sequence-detector FSMs.

## Interface
- `LEN`, default 4: pattern length in bits, 2..32.
- `PATTERN`, default 4'b1011: target sequence, `LEN` bits wide; MSB is the earliest bit received.
- `OVERLAP`, default 1: 1 means a match's tail bits may start the next match; 0 means the history is discarded after each match.
- `COUNT_W`, default 8: width of the match counter.
- `clk`, in, 1: single clock; all state changes on the rising edge.
- `rst`, in, 1: reset, synchronous, active-low; takes priority over every other input.
- `en`, in, 1: sample enable; `x` is consumed only on edges where `en`=1.
- `x`, in, 1: serial data bit.
- `match`, out, 1: one-cycle registered pulse when a match completes.
- `count`, out, `COUNT_W`: number of matches since reset; saturates at 2^`COUNT_W`-1.
- `y`, out, 2: status code.

## Operation
- Internal state:
  - `hist[LEN-1:0]`: shift register; new bit enters at the LSB.
  - `fill`: counts 0..`LEN` and saturates at `LEN`.
- Reset edge (`rst`=0): `hist`=0, `fill`=0, `match`=0, `count`=0, `y`=2'b00.
- Edge with `rst`=1, `en`=0: all state held; `match` forced to 0.
- Edge with `rst`=1, `en`=1:
  - `hist_n` = {hist[LEN-2:0], x}.
  - `fill_n` = min(`fill`+1, `LEN`).
  - `hit` = (`hist_n`==`PATTERN`) && (`fill_n`==`LEN`).
  - `match` <= `hit`.
  - On `hit`, `count` increments unless it is already all-ones; it then holds.
  - On `hit` with `OVERLAP`=0, `fill` <= 0. Otherwise `fill` <= `fill_n`.
  - `hist` <= `hist_n` in all cases.
- The `fill` gate prevents a false match from the reset-zero history; this matters for patterns containing leading zeros.
- `y` is registered and encodes one of four states, with priority top-down:
  - 2'b11 SAT: `count` is saturated.
  - 2'b10 HIT: `match`=1 this cycle.
  - 2'b01 ARMED: `fill`==`LEN`.
  - 2'b00 FILL: otherwise, including after reset.
- `y`, `count` and `match` are all updated on the same edge, so they are mutually consistent within a cycle.

## Timing
- Latency: `match` rises on the edge that samples the last pattern bit and stays high exactly one cycle, unless the next enabled bit completes another match.
- Back-to-back matches: `match` stays high on consecutive edges only when `PATTERN` self-overlaps at shift 1 with `OVERLAP`=1, e.g. all-ones.
- Reset mid-pattern: partial progress is lost; the next match needs `LEN` fresh bits.
- `en` gaps: bits are contiguous in the enabled-sample domain; the number of idle cycles between bits is irrelevant.
- Outputs never depend combinationally on inputs.

## Structure
- Shared package `seq_pkg`:
  - status constants `ST_FILL`=2'b00, `ST_ARMED`=2'b01, `ST_HIT`=2'b10, `ST_SAT`=2'b11.
  - the `y` width constant.
- One sub-module, `sat_counter` (parameter `W`; ports clk, rst, inc, q, full). It is reused by the later event counters.
- Elaboration check: `$bits(PATTERN)` must equal `LEN`, and `LEN` must be at least 2.

## Test plan
All scenarios use defaults (`LEN`=4, `PATTERN`=1011) with `en`=1 unless stated.
- Reset then x=1,0,1,1 → `match`=1 and `y`=10 after the 4th edge; `count`=1; the next x=0 gives `match`=0 and `y`=01.
- `OVERLAP`=1, x=1,0,1,1,0,1,1 → matches after edges 4 and 7; `count`=2.
- `OVERLAP`=0, same stream → a single match after edge 4; `count`=1.
- x=1,0,1, then `rst`=0 for one edge, then x=1 → no match; `count`=0; `y`=00.
- Stream 1,0,1,1 with `en`=0 for 3 cycles between every bit → exactly one match; `hist` is unchanged during the gaps.
- `COUNT_W`=2, six matches → `count` reads 1, 2, 3, 3, 3, 3; `y`=11 from the 3rd match onward while `match` still pulses; PATTERN=0011 immediately after reset with x=1,1 gives no match.
